pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Parametrised program-counter generator for the fetch stage. It is the successor to the single-cycle PC register.
- Adds stall hold, trap redirect and absolute jump-target alignment.
- Adds a configurable-depth return-address stack (RAS) for call/return.
- Adds a registered redirect flag that downstream pipeline stages use for flushing.

Parameters:
WIDTH, 32, address/data width in bits
RESET_VECTOR, 32'hBFC00000, PC value loaded at reset
RAS_DEPTH, 4, number of return-address stack entries (power of two, >=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; one clock; reset is asynchronous and active-low
stall  input  1  hold PC (pipeline hazard)
pcsrc  input  1  take branch/jump this cycle
jbmux  input  1  1 = absolute target (jumpaddress), 0 = pc-relative (pc + jumpaddress)
jumpaddress  input  WIDTH  branch offset or absolute target
is_call  input  1  qualifies a taken jump as a call (push)
is_return  input  1  return request (pop)
trap  input  1  exception/interrupt redirect
trap_vector  input  WIDTH  trap target
pc  output  WIDTH  current PC
pc_plus4  output  WIDTH  registered pc + 4
redirect  output  1  registered; 1 when pc was loaded non-sequentially last edge
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  output  1  sticky; set when a push overwrote the oldest entry

Behaviour:
Reset (rst low, asynchronous): all outputs take these values immediately.
- pc = RESET_VECTOR
- pc_plus4 = RESET_VECTOR+4
- redirect = 0, ras_count = 0, ras_overflow = 0
- RAS contents don't-care
Release from reset takes effect at the next clk edge.

Next-PC selection, combinational, strict priority:
1. trap: next = trap_vector. Overrides stall. No RAS push/pop.
2. stall: next = pc. No RAS change. pc_plus4 and redirect hold their values.
3. is_return with RAS non-empty: next = RAS top. Pop.
4. is_return with RAS empty: next = jumpaddress with bit0 cleared. No pop, ras_count stays 0.
5. pcsrc: next = jbmux ? {jumpaddress[WIDTH-1:1],1'b0} : pc + jumpaddress. Arithmetic is modulo 2^WIDTH; wrap-around is legal.
6. Otherwise: next = pc + 4, modulo 2^WIDTH.

Register update on every posedge clk outside reset:
- pc <= next
- pc_plus4 <= next + 4
- redirect <= 1 if one of rules 1, 3, 4 or 5 applied, else 0. A stalled cycle holds redirect.

RAS:
- Circular buffer of RAS_DEPTH entries with a top pointer.
- Push when pcsrc & is_call & !stall & !trap. Pushes the value of pc_plus4 at the time of the call.
- Pop when rule 3 applies.
- Push on full: overwrites the oldest entry, ras_count saturates at RAS_DEPTH, ras_overflow set to 1. ras_overflow clears only on reset.
- Simultaneous pop and push (is_return & is_call & pcsrc): target = old top; top entry replaced with pc_plus4; ras_count unchanged.
- Pop when empty: rule 4 fallback applies; ras_count never underflows.
- After an overflow, pops return the most recent RAS_DEPTH pushes in LIFO order, then the stack reads as empty.

Latency: one cycle from inputs to pc. No combinational path from inputs to any output.

Test Plan:
- Reset → sequential: assert rst low mid-cycle → pc=BFC00000 and pc_plus4=BFC00004 immediately. Release, 3 edges → pc=BFC0000C, redirect=0.
- Relative and absolute branch: pc=BFC00010, pcsrc=1, jbmux=0, jumpaddress=FFFFFFF8 → pc=BFC00008, redirect=1. Then jbmux=1, jumpaddress=00001003 → pc=00001002.
- Stall versus trap: stall=1 for 2 edges → pc unchanged. stall=1 and trap=1 with trap_vector=80000180 → pc=80000180, redirect=1, ras_count unchanged.
- Call/return: calls at pc=100 and pc=200 → ras_count=2. is_return twice → pc=204 then pc=104. Third is_return with jumpaddress=301 → pc=300, ras_count=0.
- Overflow (RAS_DEPTH=4): 5 calls at pc=10,20,30,40,50 → ras_count=4, ras_overflow=1. 5 returns → 54, 44, 34, 24, then the jumpaddress fallback.
- Wrap and simultaneous events: pc=FFFFFFFC sequential → pc=00000000, pc_plus4=00000004. is_call & is_return & pcsrc with top=44 → pc=44, ras_count unchanged, top = old pc+4.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with stall hold, trap redirect, absolute/relative
// jumps and a circular return-address stack for call/return prediction.
module pc_fetch_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       pcsrc,
  input  logic                       jbmux,
  input  logic [WIDTH-1:0]           jumpaddress,
  input  logic                       is_call,
  input  logic                       is_return,
  input  logic                       trap,
  input  logic [WIDTH-1:0]           trap_vector,
  output logic [WIDTH-1:0]           pc,
  output logic [WIDTH-1:0]           pc_plus4,
  output logic                       redirect,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] aligned_target;
  logic             redirect_next;
  logic             hold;
  logic             do_pop;
  logic             do_push;

  assign aligned_target = {jumpaddress[WIDTH-1:1], 1'b0};
  assign do_push        = pcsrc & is_call & ~stall & ~trap;

  // Strict priority: trap, stall, RAS return, empty-RAS fallback, jump, sequential.
  always_comb begin
    next_pc       = pc + WIDTH'(4);
    redirect_next = 1'b0;
    hold          = 1'b0;
    do_pop        = 1'b0;
    if (trap) begin
      next_pc       = trap_vector;
      redirect_next = 1'b1;
    end else if (stall) begin
      next_pc = pc;
      hold    = 1'b1;
    end else if (is_return && (ras_count != '0)) begin
      next_pc       = stack[top];
      redirect_next = 1'b1;
      do_pop        = 1'b1;
    end else if (is_return) begin
      next_pc       = aligned_target;
      redirect_next = 1'b1;
    end else if (pcsrc) begin
      next_pc       = jbmux ? aligned_target : pc + jumpaddress;
      redirect_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_VECTOR;
      pc_plus4 <= RESET_VECTOR + WIDTH'(4);
      redirect <= 1'b0;
    end else if (!hold) begin
      pc       <= next_pc;
      pc_plus4 <= next_pc + WIDTH'(4);
      redirect <= redirect_next;
    end
  end

  // A push on a full stack lands on the oldest slot because the buffer is circular.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top          <= '0;
      ras_count    <= '0;
      ras_overflow <= 1'b0;
    end else if (do_push && !do_pop) begin
      top <= top + PW'(1);
      if (ras_count == CW'(RAS_DEPTH)) begin
        ras_overflow <= 1'b1;
      end else begin
        ras_count <= ras_count + CW'(1);
      end
    end else if (do_pop && !do_push) begin
      top       <= top - PW'(1);
      ras_count <= ras_count - CW'(1);
    end
  end

  // A simultaneous pop and push replaces the top entry in place.
  always_ff @(posedge clk) begin
    if (do_push) begin
      stack[do_pop ? top : top + PW'(1)] <= pc_plus4;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios then random traffic,
// checked against a queue-based reference model of the fetch PC and RAS.
module tb_pc_fetch_unit;

  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, pcsrc = 1'b0, jbmux = 1'b0;
  logic        is_call = 1'b0, is_return = 1'b0, trap = 1'b0;
  logic [31:0] jumpaddress = '0, trap_vector = '0;
  logic [31:0] pc, pc_plus4;
  logic        redirect, ras_overflow;
  logic [2:0]  ras_count;

  pc_fetch_unit #(.WIDTH(WIDTH), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pcsrc(pcsrc), .jbmux(jbmux),
    .jumpaddress(jumpaddress), .is_call(is_call), .is_return(is_return),
    .trap(trap), .trap_vector(trap_vector), .pc(pc), .pc_plus4(pc_plus4),
    .redirect(redirect), .ras_count(ras_count), .ras_overflow(ras_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        red;
    logic [2:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc, m_pc4;
  logic        m_red, m_ovf;
  logic [31:0] m_ras[$];
  int          compared = 0;
  int          mismatched = 0;

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h, expected %08h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field("pc", pc, e.pc);
    check_field("pc_plus4", pc_plus4, e.pc4);
    check_field("redirect", 32'(redirect), 32'(e.red));
    check_field("ras_count", 32'(ras_count), 32'(e.cnt));
    check_field("ras_overflow", 32'(ras_overflow), 32'(e.ovf));
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.pc  = m_pc;
    e.pc4 = m_pc4;
    e.red = m_red;
    e.cnt = 3'(m_ras.size());
    e.ovf = m_ovf;
    return e;
  endfunction

  task automatic model_reset();
    m_pc  = RV;
    m_pc4 = RV + 32'd4;
    m_red = 1'b0;
    m_ovf = 1'b0;
    m_ras.delete();
  endtask

  // Drive one cycle of inputs and push the state the DUT must show after the next edge.
  task automatic apply_stimulus(input logic st, tr, ps, jb, cl, rt, input logic [31:0] ja, tv);
    logic [31:0] nxt;
    logic        was_stall;
    logic [31:0] ret_addr;
    stall = st; trap = tr; pcsrc = ps; jbmux = jb;
    is_call = cl; is_return = rt; jumpaddress = ja; trap_vector = tv;
    was_stall = 1'b0;
    ret_addr  = m_pc4;
    if (tr) begin
      nxt = tv; m_red = 1'b1;
    end else if (st) begin
      nxt = m_pc; was_stall = 1'b1;
    end else if (rt && m_ras.size() > 0) begin
      nxt = m_ras.pop_back(); m_red = 1'b1;
    end else if (rt) begin
      nxt = ja & ~32'd1; m_red = 1'b1;
    end else if (ps) begin
      nxt = jb ? (ja & ~32'd1) : m_pc + ja; m_red = 1'b1;
    end else begin
      nxt = m_pc + 32'd4; m_red = 1'b0;
    end
    if (ps && cl && !st && !tr) begin
      m_ras.push_back(ret_addr);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
    end
    if (!was_stall) begin
      m_pc  = nxt;
      m_pc4 = nxt + 32'd4;
    end
    exp_q.push_back(model_snapshot());
  endtask

  task automatic step(input logic st, tr, ps, jb, cl, rt, input logic [31:0] ja, tv);
    @(negedge clk);
    apply_stimulus(st, tr, ps, jb, cl, rt, ja, tv);
  endtask

  // Monitor: every edge that has a pending expectation is checked just after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_output(exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    #12;
    check_output(model_snapshot());

    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 32'hFFFFFFF8, 32'h0);
    step(0, 0, 1, 1, 0, 0, 32'h00001003, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 1, 0, 0, 0, 32'h40, 32'h0);
    step(1, 1, 0, 0, 0, 0, 32'h0, 32'h80000180);

    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_output(model_snapshot());
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

    step(0, 0, 1, 1, 0, 0, 32'h100, 32'h0);
    step(0, 0, 1, 1, 1, 0, 32'h200, 32'h0);
    step(0, 0, 1, 1, 1, 0, 32'h400, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h301, 32'h0);

    step(0, 0, 1, 1, 0, 0, 32'h10, 32'h0);
    for (int k = 2; k <= 6; k++) step(0, 0, 1, 1, 1, 0, 32'(k * 16), 32'h0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 1, 32'h301, 32'h0);

    step(0, 0, 1, 1, 0, 0, 32'hFFFFFFFC, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 1, 1, 0, 0, 32'h40, 32'h0);
    step(0, 0, 1, 1, 1, 0, 32'h1000, 32'h0);
    step(0, 0, 1, 0, 1, 1, 32'h8, 32'h0);
    step(0, 0, 0, 0, 0, 1, 32'h0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 4) == 0, $urandom, $urandom);
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
